// File: rtl/pet_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pet_timing_pkg
// Brief    : Shared types, constants and cycle-length helper for PET timing.
// Revision : 1.0 - initial release
// ============================================================================
package pet_timing_pkg;

    typedef enum logic [1:0] {
        SPEED_1X = 2'd0,
        SPEED_2X = 2'd1,
        SPEED_4X = 2'd2,
        SPEED_8X = 2'd3
    } speed_t;

    localparam int unsigned MIN_CYCLE = 8;

    // Slots need at least four clocks each for strobe turnaround on both sides.
    function automatic int unsigned cycle_len(input int unsigned div, input speed_t speed);
        int unsigned n;
        n = div >> speed;
        if (n < MIN_CYCLE) begin
            n = MIN_CYCLE;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pet_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pet_timing_gen_if
// Brief    : Bus, RAM-strobe and SPI handshake bundle around the timing block.
// Revision : 1.0 - initial release
// ============================================================================
interface pet_timing_gen_if;

    logic [1:0] cpu_speed_i;
    logic       halt_req_i;
    logic       spi_req_i;
    logic       spi_rw_ni;
    logic       cpu_rw_ni;
    logic       clk_cpu_o;
    logic       cpu_en_o;
    logic       spi_en_o;
    logic       spi_ack_o;
    logic       ram_oe_no;
    logic       ram_we_no;
    logic       cpu_ready_o;
    logic       cycle_start_o;

    modport master (
        input  cpu_speed_i, halt_req_i, spi_req_i, spi_rw_ni, cpu_rw_ni,
        output clk_cpu_o, cpu_en_o, spi_en_o, spi_ack_o,
               ram_oe_no, ram_we_no, cpu_ready_o, cycle_start_o
    );

    modport slave (
        output cpu_speed_i, halt_req_i, spi_req_i, spi_rw_ni, cpu_rw_ni,
        input  clk_cpu_o, cpu_en_o, spi_en_o, spi_ack_o,
               ram_oe_no, ram_we_no, cpu_ready_o, cycle_start_o
    );

endinterface
`default_nettype wire

// File: rtl/pet_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : pet_phase_counter
// Brief    : Loadable-modulus phase counter; the modulus is taken only on wrap.
// Revision : 1.0 - initial release
// ============================================================================
module pet_phase_counter #(
    parameter int unsigned     WIDTH      = 4,
    parameter logic [WIDTH-1:0] RESET_LAST = '1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_last,
    output logic      [WIDTH-1:0] o_phase,
    output logic      [WIDTH-1:0] o_phase_next,
    output logic      [WIDTH-1:0] o_last_next,
    output logic                  o_wrap
);

    logic [WIDTH-1:0] r_phase;
    logic [WIDTH-1:0] r_last;

    // Next-state values are exported so callers can register decoded outputs.
    always_comb begin
        o_wrap       = (r_phase == r_last);
        o_phase_next = o_wrap ? '0 : r_phase + WIDTH'(1);
        o_last_next  = o_wrap ? i_last : r_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_last  <= RESET_LAST;
        end else begin
            r_phase <= o_phase_next;
            r_last  <= o_last_next;
        end
    end

    assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/pet_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : pet_timing_gen
// Brief    : CPU clock divider with SPI/CPU bus slots, RAM strobes and RDY.
// Revision : 1.0 - initial release
// ============================================================================
module pet_timing_gen
    import pet_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned CNT_W   = $clog2(CLK_DIV)
) (
    input  wire logic         clk_16_i,
    input  wire logic         reset_ni,
    pet_timing_gen_if.master  bus
);

    logic [CNT_W-1:0] w_load_last;
    logic [CNT_W-1:0] w_phase;
    logic [CNT_W-1:0] w_phase_next;
    logic [CNT_W-1:0] w_last_next;
    logic             w_wrap;
    logic [CNT_W-1:0] w_half_last;
    logic [CNT_W-1:0] w_half;
    logic             w_granted_next;
    logic             w_spi_rw_next;
    logic             w_cpu_rw_next;
    logic             w_cpu_slot;
    logic             w_spi_win;
    logic             w_cpu_win;

    logic r_granted;
    logic r_spi_rw;
    logic r_cpu_rw;
    logic r_clk_cpu;
    logic r_cpu_en;
    logic r_spi_en;
    logic r_spi_ack;
    logic r_ram_oe_n;
    logic r_ram_we_n;
    logic r_cpu_ready;
    logic r_cycle_start;

    assign w_load_last = CNT_W'(cycle_len(CLK_DIV, speed_t'(bus.cpu_speed_i)) - 1);

    pet_phase_counter #(
        .WIDTH      (CNT_W),
        .RESET_LAST (CNT_W'(CLK_DIV - 1))
    ) u_phase (
        .clk          (clk_16_i),
        .rst_n        (reset_ni),
        .i_last       (w_load_last),
        .o_phase      (w_phase),
        .o_phase_next (w_phase_next),
        .o_last_next  (w_last_next),
        .o_wrap       (w_wrap)
    );

    // Everything decodes the phase being entered, so outputs come straight from flops.
    always_comb begin
        w_half_last    = w_last_next >> 1;
        w_half         = w_half_last + CNT_W'(1);
        w_granted_next = w_wrap ? bus.spi_req_i : r_granted;
        w_spi_rw_next  = w_wrap ? bus.spi_rw_ni : r_spi_rw;
        w_cpu_rw_next  = (w_phase_next == w_half) ? bus.cpu_rw_ni : r_cpu_rw;
        w_cpu_slot     = (w_phase_next >= w_half);
        w_spi_win      = w_granted_next && (w_phase_next != '0) && (w_phase_next < w_half_last);
        w_cpu_win      = (w_phase_next > w_half) && (w_phase_next < w_last_next);
    end

    always_ff @(posedge clk_16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_granted     <= 1'b0;
            r_spi_rw      <= 1'b1;
            r_cpu_rw      <= 1'b1;
            r_clk_cpu     <= 1'b0;
            r_cpu_en      <= 1'b0;
            r_spi_en      <= 1'b0;
            r_spi_ack     <= 1'b0;
            r_ram_oe_n    <= 1'b1;
            r_ram_we_n    <= 1'b1;
            r_cpu_ready   <= 1'b0;
            r_cycle_start <= 1'b0;
        end else begin
            r_granted     <= w_granted_next;
            r_spi_rw      <= w_spi_rw_next;
            r_cpu_rw      <= w_cpu_rw_next;
            r_clk_cpu     <= w_cpu_slot;
            r_cpu_en      <= w_cpu_slot;
            r_spi_en      <= w_granted_next && !w_cpu_slot;
            r_spi_ack     <= w_granted_next && (w_phase_next == w_half_last);
            r_ram_oe_n    <= !((w_spi_win && w_spi_rw_next) || (w_cpu_win && w_cpu_rw_next));
            r_ram_we_n    <= !((w_spi_win && !w_spi_rw_next) || (w_cpu_win && !w_cpu_rw_next));
            r_cycle_start <= w_wrap;
            if (w_wrap) begin
                r_cpu_ready <= !bus.halt_req_i;
            end
        end
    end

    assign bus.clk_cpu_o     = r_clk_cpu;
    assign bus.cpu_en_o      = r_cpu_en;
    assign bus.spi_en_o      = r_spi_en;
    assign bus.spi_ack_o     = r_spi_ack;
    assign bus.ram_oe_no     = r_ram_oe_n;
    assign bus.ram_we_no     = r_ram_we_n;
    assign bus.cpu_ready_o   = r_cpu_ready;
    assign bus.cycle_start_o = r_cycle_start;

    // The current phase is exported for reuse elsewhere; only its next value matters here.
    logic w_unused;
    assign w_unused = ^w_phase;

endmodule
`default_nettype wire

// File: tb/tb_pet_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pet_timing_gen
// Brief    : Random-stimulus scoreboard bench for pet_timing_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pet_timing_gen;

    localparam int unsigned CLK_DIV = 16;
    localparam logic [7:0]  RST_VEC = 8'b0000_1100;

    logic clk;
    logic reset_ni;
    int   vectors;
    int   miscompares;
    logic [7:0] exp_q[$];

    pet_timing_gen_if bus ();

    pet_timing_gen #(.CLK_DIV(CLK_DIV)) dut (
        .clk_16_i (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_vec();
        return {bus.clk_cpu_o, bus.cpu_en_o, bus.spi_en_o, bus.spi_ack_o,
                bus.ram_oe_no, bus.ram_we_no, bus.cpu_ready_o, bus.cycle_start_o};
    endfunction

    // Reference model: tracks the phase inside the current CPU cycle and applies the slot rules.
    initial begin
        int   ph;
        int   n;
        int   h;
        logic g, srw, crw, rdy, clk_c, cs, sen, ack, oe_n, we_n;
        ph = 0; n = CLK_DIV; g = 0; srw = 1; crw = 1; rdy = 0;
        forever begin
            @(posedge clk);
            if (!reset_ni) begin
                ph = 0; n = CLK_DIV; g = 0; srw = 1; crw = 1; rdy = 0;
                exp_q.push_back(RST_VEC);
            end else begin
                if (ph == n - 1) begin
                    ph  = 0;
                    n   = CLK_DIV >> bus.cpu_speed_i;
                    if (n < 8) n = 8;
                    g   = bus.spi_req_i;
                    srw = bus.spi_rw_ni;
                    rdy = !bus.halt_req_i;
                end else begin
                    ph = ph + 1;
                end
                h = n / 2;
                if (ph == h) crw = bus.cpu_rw_ni;
                clk_c = (ph >= h);
                cs    = (ph == 0);
                sen   = g && (ph < h);
                ack   = g && (ph == h - 1);
                oe_n  = !((g && srw && ph >= 1 && ph <= h - 2) || (crw && ph >= h + 1 && ph <= n - 2));
                we_n  = !((g && !srw && ph >= 1 && ph <= h - 2) || (!crw && ph >= h + 1 && ph <= n - 2));
                exp_q.push_back({clk_c, clk_c, sen, ack, oe_n, we_n, rdy, cs});
            end
        end
    end

    // Monitor: every clock the DUT presents a full output vector to be checked.
    initial begin
        logic [7:0] e;
        logic [7:0] a;
        forever begin
            @(posedge clk);
            #1;
            vectors = vectors + 1;
            a = dut_vec();
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL scoreboard_empty t=%0t actual=%b required=<entry>", $time, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL outputs t=%0t actual=%b required=%b (clk,cen,sen,ack,oe_n,we_n,rdy,cs)",
                             $time, a, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        vectors = 0;
        miscompares = 0;
        reset_ni = 1'b0;
        bus.cpu_speed_i = 2'd0;
        bus.halt_req_i  = 1'b0;
        bus.spi_req_i   = 1'b0;
        bus.spi_rw_ni   = 1'b1;
        bus.cpu_rw_ni   = 1'b1;
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        repeat (48) @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) bus.cpu_speed_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  bus.spi_req_i   = !bus.spi_req_i;
            if ($urandom_range(0, 29) == 0) bus.halt_req_i  = !bus.halt_req_i;
            bus.spi_rw_ni = 1'($urandom_range(0, 1));
            bus.cpu_rw_ni = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                reset_ni = 1'b0;
                #1;
                vectors = vectors + 1;
                if (dut_vec() !== RST_VEC) begin
                    miscompares = miscompares + 1;
                    $display("FAIL async_reset t=%0t actual=%b required=%b", $time, dut_vec(), RST_VEC);
                end
                @(negedge clk);
                reset_ni = 1'b1;
            end
        end
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
